ex_muldiv_unit: RTL and testbench

- Iterative HI/LO multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands and decoded mul/div opcode.
- Owns the architectural HI/LO registers.
- Drives the EX-stage stall while a long operation blocks a dependent instruction.
- Implements MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO for the 32-bit datapath.

---
 rtl/ex_muldiv_unit_if.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
// Connects the EX stage to the HI/LO multiply/divide unit. It carries the
// issue signals and operands from EX, and returns stall, busy, MFHI/MFLO
// data and the HI/LO registers.
interface ex_muldiv_unit_if;
    logic        Valid;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Abort;
    logic        Stall;
    logic        Busy;
    logic [31:0] Result;
    logic [31:0] Hi;
    logic [31:0] Lo;

    // EX stage side: issues instructions and consumes stall/result
    modport master (
        output Valid, Op, A, B, Abort,
        input  Stall, Busy, Result, Hi, Lo
    );

    // Unit side: consumes instructions and owns HI/LO
    modport slave (
        input  Valid, Op, A, B, Abort,
        output Stall, Busy, Result, Hi, Lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative HI/LO multiply/divide unit for the EX stage. It implements
// MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
// Multiply uses shift-add and divide uses restoring division. Each produces
// one bit per cycle on operand magnitudes. A final FIX cycle applies the
// sign correction and writes HI/LO.
// Optional macro MULDIV_FAST_MULT_EN replaces the iterative multiply with a
// single-cycle combinational multiplier. Divides stay iterative.
module ex_muldiv_unit #(
    parameter logic [31:0] HILO_RST_VAL = 32'h0
) (
    input  logic            CLK,
    input  logic            RST_N,
    ex_muldiv_unit_if.slave bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    // r_acc holds {partial product high, multiplier} during a multiply
    // and {remainder, dividend/quotient} during a divide.
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_operand;
    logic        r_isDiv;
    logic        r_negProd;
    logic        r_negQuo;
    logic        r_negRem;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_isMul;
    logic        w_isDiv;
    logic        w_signedOp;
    logic        w_canAccept;
    logic        w_acceptMulIter;
    logic        w_acceptDiv;
    logic        w_acceptMthi;
    logic        w_acceptMtlo;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic        w_signsDiffer;

    logic [32:0] w_mulSum;
    logic [32:0] w_divShift;
    logic        w_divFits;
    logic [31:0] w_divRem;

    logic [63:0] w_prodFix;
    logic [31:0] w_quoFix;
    logic [31:0] w_remFix;
    logic [31:0] w_fixHi;
    logic [31:0] w_fixLo;

    assign w_isMul       = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU);
    assign w_isDiv       = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
    assign w_signedOp    = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    assign w_canAccept   = bus.Valid & ~bus.Abort & (r_state == ST_IDLE);
    assign w_acceptDiv   = w_canAccept & w_isDiv;
    assign w_acceptMthi  = w_canAccept & (bus.Op == OP_MTHI);
    assign w_acceptMtlo  = w_canAccept & (bus.Op == OP_MTLO);

    assign w_absA        = (w_signedOp & bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    assign w_absB        = (w_signedOp & bus.B[31]) ? (32'd0 - bus.B) : bus.B;
    assign w_signsDiffer = w_signedOp & (bus.A[31] ^ bus.B[31]);

`ifdef MULDIV_FAST_MULT_EN
    // Sign-extending both operands to 64 bits gives the correct low 64
    // product bits for both signed and unsigned multiplies.
    logic [63:0] w_fastA;
    logic [63:0] w_fastB;
    logic [63:0] w_fastProd;
    logic        w_acceptFastMul;

    assign w_fastA         = {{32{w_signedOp & bus.A[31]}}, bus.A};
    assign w_fastB         = {{32{w_signedOp & bus.B[31]}}, bus.B};
    assign w_fastProd      = w_fastA * w_fastB;
    assign w_acceptFastMul = w_canAccept & w_isMul;
    assign w_acceptMulIter = 1'b0;
`else
    assign w_acceptMulIter = w_canAccept & w_isMul;
`endif

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign w_mulSum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);

    // Restoring step: shift the next dividend bit into the remainder, then
    // subtract the divisor if it fits. The fit test becomes the quotient bit.
    assign w_divShift = {r_acc[63:32], r_acc[31]};
    assign w_divFits  = (w_divShift >= {1'b0, r_operand});
    assign w_divRem   = w_divFits ? 32'(w_divShift - {1'b0, r_operand}) : w_divShift[31:0];

    // Sign fix-up applied at the FIX cycle. A divide by zero leaves the
    // quotient at all-ones because r_negQuo is never set when B is zero.
    assign w_prodFix  = r_negProd ? (64'd0 - r_acc) : r_acc;
    assign w_quoFix   = r_negQuo ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_remFix   = r_negRem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_fixHi    = r_isDiv ? w_remFix : w_prodFix[63:32];
    assign w_fixLo    = r_isDiv ? w_quoFix : w_prodFix[31:0];

    // State register; reset discards any operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Abort drops back to IDLE from any busy state.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acceptMulIter) begin
                    w_nextState = ST_MUL;
                end else if (w_acceptDiv) begin
                    w_nextState = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.Abort) begin
                    w_nextState = ST_IDLE;
                end else if (r_count == 5'd0) begin
                    w_nextState = ST_FIX;
                end
            end
            ST_FIX: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Iterative datapath: capture magnitudes and sign flags at accept,
    // then perform one multiply or divide bit per cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_acc     <= 64'd0;
            r_operand <= 32'd0;
            r_count   <= 5'd0;
            r_isDiv   <= 1'b0;
            r_negProd <= 1'b0;
            r_negQuo  <= 1'b0;
            r_negRem  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acceptMulIter) begin
                        r_acc     <= {32'd0, w_absB};
                        r_operand <= w_absA;
                        r_count   <= 5'd31;
                        r_isDiv   <= 1'b0;
                        r_negProd <= w_signsDiffer;
                    end else if (w_acceptDiv) begin
                        r_acc     <= {32'd0, w_absA};
                        r_operand <= w_absB;
                        r_count   <= 5'd31;
                        r_isDiv   <= 1'b1;
                        r_negQuo  <= w_signsDiffer & (bus.B != 32'd0);
                        r_negRem  <= w_signedOp & bus.A[31];
                    end
                end
                ST_MUL: begin
                    if (bus.Abort) begin
                        r_count <= 5'd0;
                    end else begin
                        r_acc <= {w_mulSum, r_acc[31:1]};
                        if (r_count != 5'd0) begin
                            r_count <= r_count - 5'd1;
                        end
                    end
                end
                ST_DIV: begin
                    if (bus.Abort) begin
                        r_count <= 5'd0;
                    end else begin
                        r_acc <= {w_divRem, r_acc[30:0], w_divFits};
                        if (r_count != 5'd0) begin
                            r_count <= r_count - 5'd1;
                        end
                    end
                end
                default: begin
                    r_count <= 5'd0;
                end
            endcase
        end
    end

    // Architectural HI/LO. They are written by the FIX cycle unless it is
    // aborted, by a fast multiply if enabled, or by MTHI/MTLO in IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hi <= HILO_RST_VAL;
            r_lo <= HILO_RST_VAL;
        end else if (r_state == ST_FIX) begin
            if (!bus.Abort) begin
                r_hi <= w_fixHi;
                r_lo <= w_fixLo;
            end
`ifdef MULDIV_FAST_MULT_EN
        end else if (w_acceptFastMul) begin
            r_hi <= w_fastProd[63:32];
            r_lo <= w_fastProd[31:0];
`endif
        end else begin
            if (w_acceptMthi) begin
                r_hi <= bus.A;
            end
            if (w_acceptMtlo) begin
                r_lo <= bus.A;
            end
        end
    end

    // MFHI/MFLO read path; every other opcode returns zero.
    always_comb begin
        bus.Result = 32'd0;
        case (bus.Op)
            OP_MFHI: bus.Result = r_hi;
            OP_MFLO: bus.Result = r_lo;
            default: bus.Result = 32'd0;
        endcase
    end

    // Only mul/div-class instructions wait on a busy unit; ALU ops pass.
    assign bus.Stall = bus.Valid & ~bus.Abort & (r_state != ST_IDLE) &
                       (bus.Op >= OP_MULT) & (bus.Op <= OP_MFLO);
    assign bus.Busy  = (r_state != ST_IDLE);
    assign bus.Hi    = r_hi;
    assign bus.Lo    = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
// Scoreboard bench for ex_muldiv_unit. Expected HI/LO values are queued when
// an op is issued. A monitor pops and compares them each time Busy falls.
// Define MULDIV_FAST_MULT_EN to exercise the single-cycle multiply build.
module tb_ex_muldiv_unit;

    localparam logic [31:0] RST_VAL = 32'h1234_5678;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ex_muldiv_unit_if bus();

    ex_muldiv_unit #(.HILO_RST_VAL(RST_VAL)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        bit          chkLen;
    } exp_t;

    exp_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          stallCnt;
    int          stallSeen;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, then lets comb settle.
    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic abort);
        @(negedge clk);
        bus.Valid = v;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.Abort = abort;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, $urandom, $urandom, 1'b0);
    endtask

    task automatic pushExp(input string name, input logic [31:0] hi, input logic [31:0] lo,
                           input int len, input bit chkLen);
        exp_t e;
        e.name   = name;
        e.hi     = hi;
        e.lo     = lo;
        e.len    = len;
        e.chkLen = chkLen;
        expQ.push_back(e);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (bus.Busy === 1'b1 && n < 200) begin
            idleCycle();
            n++;
        end
        if (bus.Busy !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: Busy=%b still set after %0d cycles", name, bus.Busy, n);
        end
    endtask

    // Issues one iterative op with changing operands afterwards and waits out
    // its full latency; the monitor does the HI/LO comparison.
    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        pushExp(name, hi, lo, 33, 1'b1);
        applyStimulus(1'b1, op, a, b, 1'b0);
        idleCycle();
        waitIdle(name);
        expHi = hi;
        expLo = lo;
    endtask

    // Monitor: on every Busy falling edge, compare HI/LO and busy length
    // against the oldest queued expectation.
    logic prevBusy = 1'b0;
    int   busyCnt  = 0;
    exp_t monE;

    always @(negedge clk) begin
        if (bus.Busy === 1'b1) begin
            busyCnt++;
        end else if (prevBusy) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_completion: Hi=0x%08h Lo=0x%08h with empty queue", bus.Hi, bus.Lo);
            end else begin
                monE = expQ.pop_front();
                checkOutput({monE.name, "_hi"}, bus.Hi, monE.hi);
                checkOutput({monE.name, "_lo"}, bus.Lo, monE.lo);
                if (monE.chkLen) begin
                    checkOutput({monE.name, "_busylen"}, 32'(busyCnt), 32'(monE.len));
                end
            end
            busyCnt = 0;
        end
        prevBusy = (bus.Busy === 1'b1);
    end

    // Watchdog in case the DUT never lets the bench proceed.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        bus.Valid = 1'b0;
        bus.Op    = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.Abort = 1'b0;
        expHi     = RST_VAL;
        expLo     = RST_VAL;

        #2 rst_n = 1'b0;
        #1;
        bus.Valid = 1'b1;
        bus.Op    = 4'd1;
        #1;
        checkOutput("rst_hi", bus.Hi, RST_VAL);
        checkOutput("rst_lo", bus.Lo, RST_VAL);
        checkOutput("rst_busy", 32'(bus.Busy), 32'd0);
        checkOutput("rst_stall", 32'(bus.Stall), 32'd0);
        bus.Op = 4'd7;
        #1;
        checkOutput("rst_mfhi_result", bus.Result, RST_VAL);
        bus.Valid = 1'b0;
        bus.Op    = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MULDIV_FAST_MULT_EN
        applyStimulus(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        applyStimulus(1'b1, 4'd8, $urandom, $urandom, 1'b0);
        checkOutput("fast_mult_hi", bus.Hi, 32'hFFFF_FFFF);
        checkOutput("fast_mult_lo", bus.Lo, 32'hFFFF_FFFA);
        checkOutput("fast_mult_busy", 32'(bus.Busy), 32'd0);
        checkOutput("fast_mflo_stall", 32'(bus.Stall), 32'd0);
        checkOutput("fast_mflo_result", bus.Result, 32'hFFFF_FFFA);
        idleCycle();
`else
        runOp("mult_m1x2", 4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp("multu_ffx2", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
`endif
        runOp("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu_100_0", 4'd4, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        runOp("div_m5_0", 4'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        runOp("div_min_m1", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        runOp("divu_big", 4'd4, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999);

`ifndef MULDIV_FAST_MULT_EN
        // MFLO held behind a multiply stalls for the full latency
        pushExp("mult_3x5", 32'd0, 32'd15, 33, 1'b1);
        applyStimulus(1'b1, 4'd1, 32'd3, 32'd5, 1'b0);
        stallCnt = 0;
        applyStimulus(1'b1, 4'd8, $urandom, $urandom, 1'b0);
        while (bus.Stall === 1'b1 && stallCnt < 100) begin
            stallCnt++;
            applyStimulus(1'b1, 4'd8, $urandom, $urandom, 1'b0);
        end
        checkOutput("mflo_stall_cycles", 32'(stallCnt), 32'd33);
        checkOutput("mflo_result", bus.Result, 32'd15);
        expHi = 32'd0;
        expLo = 32'd15;
        idleCycle();

        // ALU ops (NOP and reserved opcodes) never stall while busy
        pushExp("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b1);
        applyStimulus(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        stallSeen = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 4'd0 : 4'd12, $urandom, $urandom, 1'b0);
            if (bus.Stall !== 1'b0) stallSeen++;
        end
        checkOutput("alu_no_stall", 32'(stallSeen), 32'd0);
        idleCycle();
        waitIdle("mult_m3x5");
        expHi = 32'hFFFF_FFFF;
        expLo = 32'hFFFF_FFF1;
`endif

        // MTHI/MTLO are single-cycle and readable via MFHI/MFLO
        applyStimulus(1'b1, 4'd5, 32'h0000_AAAA, $urandom, 1'b0);
        applyStimulus(1'b1, 4'd6, 32'h0000_5555, $urandom, 1'b0);
        checkOutput("mthi_hi", bus.Hi, 32'h0000_AAAA);
        checkOutput("mthi_busy", 32'(bus.Busy), 32'd0);
        applyStimulus(1'b1, 4'd7, $urandom, $urandom, 1'b0);
        checkOutput("mtlo_lo", bus.Lo, 32'h0000_5555);
        checkOutput("mtlo_hi_kept", bus.Hi, 32'h0000_AAAA);
        checkOutput("mfhi_result", bus.Result, 32'h0000_AAAA);
        applyStimulus(1'b1, 4'd8, $urandom, $urandom, 1'b0);
        checkOutput("mflo_idle_result", bus.Result, 32'h0000_5555);
        checkOutput("mflo_idle_stall", 32'(bus.Stall), 32'd0);
        expHi = 32'h0000_AAAA;
        expLo = 32'h0000_5555;
        idleCycle();

        // DIVU aborted in cycle 10 leaves HI/LO untouched
        pushExp("divu_abort", expHi, expLo, 0, 1'b0);
        applyStimulus(1'b1, 4'd4, 32'd50, 32'd7, 1'b0);
        repeat (9) idleCycle();
        applyStimulus(1'b1, 4'd8, $urandom, $urandom, 1'b1);
        checkOutput("abort_stall_masked", 32'(bus.Stall), 32'd0);
        checkOutput("abort_busy_before", 32'(bus.Busy), 32'd1);
        idleCycle();
        checkOutput("abort_busy_cleared", 32'(bus.Busy), 32'd0);
        checkOutput("abort_hi", bus.Hi, 32'h0000_AAAA);
        checkOutput("abort_lo", bus.Lo, 32'h0000_5555);

        // Back-to-back: DIVU stalled behind DIV is accepted when stall drops
        pushExp("b2b_div", 32'hFFFF_FFFE, 32'hFFFF_FFF2, 33, 1'b1);
        pushExp("b2b_divu", 32'd1, 32'd3, 33, 1'b1);
        applyStimulus(1'b1, 4'd3, 32'hFFFF_FF9C, 32'd7, 1'b0);
        stallCnt = 0;
        applyStimulus(1'b1, 4'd4, 32'd7, 32'd2, 1'b0);
        while (bus.Stall === 1'b1 && stallCnt < 100) begin
            stallCnt++;
            applyStimulus(1'b1, 4'd4, 32'd7, 32'd2, 1'b0);
        end
        checkOutput("b2b_stall_cycles", 32'(stallCnt), 32'd33);
        checkOutput("b2b_hi_visible", bus.Hi, 32'hFFFF_FFFE);
        idleCycle();
        checkOutput("b2b_accepted", 32'(bus.Busy), 32'd1);
        waitIdle("b2b_divu");
        expHi = 32'd1;
        expLo = 32'd3;

        // Abort during the FIX cycle suppresses the HI/LO write
        pushExp("divu_fixabort", expHi, expLo, 33, 1'b1);
        applyStimulus(1'b1, 4'd4, 32'd1000, 32'd3, 1'b0);
        repeat (32) idleCycle();
        applyStimulus(1'b0, 4'd0, $urandom, $urandom, 1'b1);
        checkOutput("fix_busy", 32'(bus.Busy), 32'd1);
        idleCycle();
        checkOutput("fixabort_busy", 32'(bus.Busy), 32'd0);
        checkOutput("fixabort_hi", bus.Hi, 32'd1);
        checkOutput("fixabort_lo", bus.Lo, 32'd3);

        // Asynchronous reset in the middle of a divide
        pushExp("div_reset", RST_VAL, RST_VAL, 0, 1'b0);
        applyStimulus(1'b1, 4'd3, 32'd1000, 32'hFFFF_FFFD, 1'b0);
        repeat (19) idleCycle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(bus.Busy), 32'd0);
        checkOutput("rst_mid_hi", bus.Hi, RST_VAL);
        checkOutput("rst_mid_lo", bus.Lo, RST_VAL);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expHi = RST_VAL;
        expLo = RST_VAL;

        // Fresh multiply after reset
`ifdef MULDIV_FAST_MULT_EN
        applyStimulus(1'b1, 4'd2, 32'd7, 32'd6, 1'b0);
        idleCycle();
        checkOutput("multu_7x6_hi", bus.Hi, 32'd0);
        checkOutput("multu_7x6_lo", bus.Lo, 32'd42);
        checkOutput("multu_7x6_busy", 32'(bus.Busy), 32'd0);
`else
        runOp("multu_7x6", 4'd2, 32'd7, 32'd6, 32'd0, 32'd42);
`endif

        repeat (3) idleCycle();
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
